key_event_scheduler: RTL and testbench

// Sits between the PS/2 keyboard front-end and character consumers (terminal, console).
// - Queues ASCII key presses in a small FIFO and delivers them over a valid/ready handshake.
// - Adds typematic auto-repeat for a held key: a first repeat after DELAY_CYC, then one every REPEAT_CYC.
// - Applies Ctrl mapping to letters, so Ctrl+letter yields codes 0x01-0x1A.
//

---
 rtl/key_event_scheduler.sv | 162 ++++++++++++++++
 tb/tb_key_event_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_scheduler.sv
// Key event scheduler: queues ASCII key presses in a show-ahead FIFO, adds
// typematic auto-repeat for the held key and applies Ctrl mapping to letters.
module key_event_scheduler #(
  parameter int DEPTH      = 8,
  parameter int DELAY_CYC  = 25000000,
  parameter int REPEAT_CYC = 2500000,
  parameter int CW         = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_new,
  input  logic [7:0]               key_code,
  input  logic                     key_is_ascii,
  input  logic [7:0]               key_ascii,
  input  logic                     ctrl,
  output logic                     ev_valid,
  output logic [7:0]               ev_data,
  output logic                     ev_repeat,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] DELAY_END  = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] REPEAT_END = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_counter;
  logic [7:0]    r_held_code;
  logic [7:0]    r_held_ch;

  // Each entry is {repeat flag, character}.
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic       w_is_letter;
  logic [7:0] w_ch;
  logic       w_press;
  logic       w_hold;
  logic       w_rep_due;
  logic       w_push;
  logic [8:0] w_push_word;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr_en;
  logic       w_drop;

  assign w_is_letter = ((key_ascii >= 8'h41) && (key_ascii <= 8'h5A)) ||
                       ((key_ascii >= 8'h61) && (key_ascii <= 8'h7A));
  assign w_ch        = (ctrl && w_is_letter) ? (key_ascii & 8'h1F) : key_ascii;

  assign w_press   = key_new && key_is_ascii;
  assign w_hold    = (key_code == r_held_code);
  assign w_rep_due = w_hold &&
                     (((r_state == S_DELAY)  && (r_counter == DELAY_END)) ||
                      ((r_state == S_REPEAT) && (r_counter == REPEAT_END)));

  // A fresh press always beats a repeat falling due in the same cycle.
  assign w_push      = w_press || w_rep_due;
  assign w_push_word = w_press ? {1'b0, w_ch} : {1'b1, r_held_ch};

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && ev_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_counter   <= '0;
      r_held_code <= '0;
      r_held_ch   <= '0;
    end else if (w_press) begin
      r_state     <= S_DELAY;
      r_counter   <= '0;
      r_held_code <= key_code;
      r_held_ch   <= w_ch;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (!w_hold) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
          end else if (r_counter == DELAY_END) begin
            r_state   <= S_REPEAT;
            r_counter <= '0;
          end else begin
            r_counter <= r_counter + CW'(1);
          end
        end
        S_REPEAT: begin
          if (!w_hold) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
          end else if (r_counter == REPEAT_END) begin
            r_counter <= '0;
          end else begin
            r_counter <= r_counter + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_counter <= '0;
        end
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ev_valid  = !w_empty;
  assign ev_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
  assign ev_repeat = w_empty ? 1'b0  : r_mem[r_rd_ptr][8];
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: each task drives one scenario and
// checks popped events (logged with their cycle) against hand-computed values.
module tb_key_event_scheduler;

  logic       clk;
  logic       rst;
  logic       key_new;
  logic [7:0] key_code;
  logic       key_is_ascii;
  logic [7:0] key_ascii;
  logic       ctrl;
  logic       ev_valid;
  logic [7:0] ev_data;
  logic       ev_repeat;
  logic       ev_ready;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] d;
    logic       r;
    int         c;
  } ev_t;
  ev_t log_q[$];

  key_event_scheduler #(
    .DEPTH(4), .DELAY_CYC(20), .REPEAT_CYC(5), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .key_new(key_new), .key_code(key_code),
    .key_is_ascii(key_is_ascii), .key_ascii(key_ascii), .ctrl(ctrl),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_repeat(ev_repeat),
    .ev_ready(ev_ready), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      log_q.push_back('{ev_data, ev_repeat, cyc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", ev_valid); end
    n_vec++; if (ev_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h expected 00", ev_data); end
    n_vec++; if (ev_repeat !== 1'b0) begin n_err++; $display("FAIL reset_repeat: got %0b expected 0", ev_repeat); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    @(posedge clk); #1;
    rst = 1'b0;
    ev_ready = 1'b1;
    tick(3);
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL ready_on_empty_count: got %0d expected 0", count); end
    $display("test_reset: done");
  endtask

  task automatic test_single_press;
    int p;
    ev_t e;
    log_q.delete();
    ev_ready = 1'b1;
    p = cyc;
    key_new = 1'b1; key_code = 8'h1C; key_is_ascii = 1'b1; key_ascii = 8'h61;
    tick(1);
    key_new = 1'b0;
    tick(2);
    key_code = 8'h00;
    tick(30);
    n_vec++; if (log_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d events expected 1", log_q.size()); end
    if (log_q.size() >= 1) begin
      e = log_q[0];
      n_vec++; if (e.d !== 8'h61 || e.r !== 1'b0 || e.c != p + 1) begin
        n_err++; $display("FAIL single_event: got %02h rep=%0b cyc=%0d expected 61 rep=0 cyc=%0d", e.d, e.r, e.c, p + 1);
      end
    end
    $display("test_single_press: %0d events", log_q.size());
  endtask

  task automatic test_hold_repeat;
    int p;
    int n;
    ev_t e;
    int off[5] = '{0, 20, 25, 30, 35};
    log_q.delete();
    ev_ready = 1'b1;
    p = cyc;
    key_new = 1'b1; key_code = 8'h1C; key_is_ascii = 1'b1; key_ascii = 8'h61;
    tick(1);
    key_new = 1'b0;
    tick(39);
    key_code = 8'h00;
    tick(30);
    n_vec++; if (log_q.size() != 5) begin n_err++; $display("FAIL hold_count: got %0d events expected 5", log_q.size()); end
    n = (log_q.size() < 5) ? log_q.size() : 5;
    for (int i = 0; i < n; i++) begin
      e = log_q[i];
      n_vec++; if (e.d !== 8'h61 || e.r !== (i != 0) || e.c != p + 1 + off[i]) begin
        n_err++; $display("FAIL hold_event%0d: got %02h rep=%0b cyc=%0d expected 61 rep=%0b cyc=%0d", i, e.d, e.r, e.c, (i != 0), p + 1 + off[i]);
      end
    end
    $display("test_hold_repeat: %0d events", log_q.size());
  endtask

  task automatic test_overflow;
    int n;
    ev_t e;
    logic [7:0] exp_d[5] = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h76};
    log_q.delete();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_new = 1'b1; key_code = 8'h10 + 8'(i); key_is_ascii = 1'b1; key_ascii = 8'h70 + 8'(i);
      tick(1);
      key_new = 1'b0; key_code = 8'h00;
      tick(1);
    end
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d expected 4", count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    n_vec++; if (ev_valid !== 1'b1 || ev_data !== 8'h70 || ev_repeat !== 1'b0) begin
      n_err++; $display("FAIL ovf_head: got v=%0b %02h rep=%0b expected v=1 70 rep=0", ev_valid, ev_data, ev_repeat);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %0b expected 0", overflow); end
    // full FIFO with push and pop together
    ev_ready = 1'b1;
    key_new = 1'b1; key_code = 8'h20; key_is_ascii = 1'b1; key_ascii = 8'h76;
    tick(1);
    key_new = 1'b0; key_code = 8'h00; ev_ready = 1'b0;
    n_vec++; if (count !== 3'd4 || overflow !== 1'b0 || ev_data !== 8'h71) begin
      n_err++; $display("FAIL full_push_pop: got count=%0d ovf=%0b head=%02h expected count=4 ovf=0 head=71", count, overflow, ev_data);
    end
    tick(3);
    n_vec++; if (ev_data !== 8'h71) begin n_err++; $display("FAIL head_stable: got %02h expected 71", ev_data); end
    ev_ready = 1'b1;
    tick(6);
    n_vec++; if (log_q.size() != 5) begin n_err++; $display("FAIL drain_count: got %0d events expected 5", log_q.size()); end
    n = (log_q.size() < 5) ? log_q.size() : 5;
    for (int i = 0; i < n; i++) begin
      e = log_q[i];
      n_vec++; if (e.d !== exp_d[i] || e.r !== 1'b0) begin
        n_err++; $display("FAIL drain_event%0d: got %02h rep=%0b expected %02h rep=0", i, e.d, e.r, exp_d[i]);
      end
    end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_empty: got %0d expected 0", count); end
    $display("test_overflow: %0d events drained", log_q.size());
  endtask

  task automatic test_ctrl_map;
    int n;
    ev_t e;
    logic [7:0] in_a[5]  = '{8'h43, 8'h31, 8'h7A, 8'h5B, 8'h40};
    logic [7:0] exp_d[5] = '{8'h03, 8'h31, 8'h1A, 8'h5B, 8'h40};
    log_q.delete();
    ev_ready = 1'b1;
    ctrl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_new = 1'b1; key_code = 8'h21 + 8'(i); key_is_ascii = 1'b1; key_ascii = in_a[i];
      tick(1);
      key_new = 1'b0; key_code = 8'h00;
      tick(2);
    end
    ctrl = 1'b0;
    tick(3);
    n_vec++; if (log_q.size() != 5) begin n_err++; $display("FAIL ctrl_count: got %0d events expected 5", log_q.size()); end
    n = (log_q.size() < 5) ? log_q.size() : 5;
    for (int i = 0; i < n; i++) begin
      e = log_q[i];
      n_vec++; if (e.d !== exp_d[i] || e.r !== 1'b0) begin
        n_err++; $display("FAIL ctrl_event%0d: got %02h rep=%0b expected %02h rep=0", i, e.d, e.r, exp_d[i]);
      end
    end
    $display("test_ctrl_map: %0d events", log_q.size());
  endtask

  task automatic test_preempt;
    int p;
    int n;
    ev_t e;
    logic [7:0] exp_d[5] = '{8'h61, 8'h61, 8'h61, 8'h62, 8'h62};
    logic       exp_r[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int         off[5]   = '{1, 21, 26, 31, 51};
    log_q.delete();
    ev_ready = 1'b1;
    p = cyc;
    key_new = 1'b1; key_code = 8'h1C; key_is_ascii = 1'b1; key_ascii = 8'h61;
    tick(1);
    key_new = 1'b0;
    tick(29);
    // 'a' repeat is due in this very cycle
    key_new = 1'b1; key_code = 8'h32; key_ascii = 8'h62;
    tick(1);
    key_new = 1'b0;
    tick(21);
    key_code = 8'h00;
    tick(30);
    n_vec++; if (log_q.size() != 5) begin n_err++; $display("FAIL preempt_count: got %0d events expected 5", log_q.size()); end
    n = (log_q.size() < 5) ? log_q.size() : 5;
    for (int i = 0; i < n; i++) begin
      e = log_q[i];
      n_vec++; if (e.d !== exp_d[i] || e.r !== exp_r[i] || e.c != p + off[i]) begin
        n_err++; $display("FAIL preempt_event%0d: got %02h rep=%0b cyc=%0d expected %02h rep=%0b cyc=%0d", i, e.d, e.r, e.c, exp_d[i], exp_r[i], p + off[i]);
      end
    end
    $display("test_preempt: %0d events", log_q.size());
  endtask

  task automatic test_reset_mid;
    log_q.delete();
    ev_ready = 1'b0;
    key_new = 1'b1; key_code = 8'h1C; key_is_ascii = 1'b1; key_ascii = 8'h61;
    tick(1);
    key_new = 1'b0;
    tick(25);
    n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_reset_count: got %0d expected 3", count); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (ev_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0 || ev_data !== 8'h00) begin
      n_err++; $display("FAIL mid_reset: got v=%0b count=%0d ovf=%0b data=%02h expected v=0 count=0 ovf=0 data=00", ev_valid, count, overflow, ev_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ev_ready = 1'b1;
    tick(30);
    key_code = 8'h00;
    n_vec++; if (log_q.size() != 0) begin n_err++; $display("FAIL post_reset_events: got %0d events expected 0", log_q.size()); end
    $display("test_reset_mid: %0d events after reset", log_q.size());
  endtask

  initial begin
    rst = 1'b1; key_new = 1'b0; key_code = 8'h00; key_is_ascii = 1'b0;
    key_ascii = 8'h00; ctrl = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_overflow();
    test_ctrl_map();
    test_preempt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
